// File: rtl/t05_cb_walker.sv
// t05_cb_walker -- Huffman codebook generator.
// Walks the Huffman tree held in node SRAM depth-first (left edge first) and
// emits one {symbol, code, length} record per leaf over a valid/ready handshake.
//
// Ports:
//   clk, rst (async, active-high), en (low = all registers hold)
//   start, root_index            : begin a walk from root_index
//   rd_req, rd_addr              : one-cycle node read request
//   rd_valid, rd_left, rd_right  : node read response (child fields)
//   code_valid/ready, code_sym, code_bits, code_len : record stream
//   sym_count                    : records accepted in the current walk
//   busy, done, error            : walk status
//
// Build option: CB_NODE_STACK_EN keeps a per-depth node stack so backing up
// to a parent costs one read; without it the parent is found again by
// re-walking from the root along the stored path bits.
module t05_cb_walker #(
  parameter  int IDX_W     = 7,
  parameter  int SYM_W     = 8,
  parameter  int MAX_DEPTH = 128,
  localparam int CHILD_W   = SYM_W + 1,
  localparam int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [IDX_W-1:0]     root_index,
  output logic                 rd_req,
  output logic [IDX_W-1:0]     rd_addr,
  input  logic                 rd_valid,
  input  logic [CHILD_W-1:0]   rd_left,
  input  logic [CHILD_W-1:0]   rd_right,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic [SYM_W-1:0]     code_sym,
  output logic [MAX_DEPTH-1:0] code_bits,
  output logic [LEN_W-1:0]     code_len,
  output logic [SYM_W:0]       sym_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int                 SP_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [CHILD_W-1:0] NULL_C  = {2'b11, {(SYM_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_DEPTH);
  localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
  localparam logic [SYM_W:0]     CNT_ONE = (SYM_W+1)'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LEFT, S_RIGHT, S_EMIT, S_BACK, S_REWALK, S_DONE, S_ERROR
  } state_t;

  state_t               state, ret_st, emit_ret;
  logic [MAX_DEPTH-1:0] path;      // edges to current node, LSB = most recent
  logic [LEN_W-1:0]     len;       // depth of current node
  logic [CHILD_W-1:0]   left_c, right_c;

  logic                 is_right, c_null, c_leaf, at_max;
  logic [CHILD_W-1:0]   cur;
  logic [LEN_W-1:0]     len_inc, len_dec;
  logic [MAX_DEPTH-1:0] path_push;

  // LEFT and RIGHT share one decision path; only the child and edge bit differ.
  assign is_right  = (state == S_RIGHT);
  assign cur       = is_right ? right_c : left_c;
  assign c_null    = (cur == NULL_C);
  assign c_leaf    = ~cur[SYM_W];
  assign at_max    = (len == LEN_MAX);
  assign len_inc   = len + LEN_ONE;
  assign len_dec   = len - LEN_ONE;
  assign path_push = {path[MAX_DEPTH-2:0], is_right};

`ifdef CB_NODE_STACK_EN
  // stack[d] = node at depth d. rd_addr always names the node whose children
  // are captured, so it is the node being descended from.
  logic [IDX_W-1:0] stack [MAX_DEPTH];
  logic [IDX_W-1:0] parent;
  logic             descend;

  assign descend = en & (state == S_LEFT | state == S_RIGHT) & ~c_null & ~c_leaf & ~at_max;
  assign parent  = stack[SP_W'(len_dec)];

  always_ff @(posedge clk)
    if (descend) stack[SP_W'(len)] <= rd_addr;
`else
  // Re-walk: k counts edges already followed from the root; the edge leaving
  // depth k sits at path bit len-1-k.
  logic [IDX_W-1:0] root, rw_child;
  logic [LEN_W-1:0] k;
  logic [SP_W-1:0]  rw_pos;

  assign rw_pos   = SP_W'(len - k - LEN_ONE);
  assign rw_child = path[rw_pos] ? right_c[IDX_W-1:0] : left_c[IDX_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ret_st     <= S_LEFT;
      emit_ret   <= S_RIGHT;
      path       <= '0;
      len        <= '0;
      left_c     <= '0;
      right_c    <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      code_valid <= 1'b0;
      code_sym   <= '0;
      code_bits  <= '0;
      code_len   <= '0;
      sym_count  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifndef CB_NODE_STACK_EN
      root       <= '0;
      k          <= '0;
`endif
    end else if (en) begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          path      <= '0;
          len       <= '0;
          sym_count <= '0;
          done      <= 1'b0;
          error     <= 1'b0;
          busy      <= 1'b1;
          rd_req    <= 1'b1;
          rd_addr   <= root_index;
          ret_st    <= S_LEFT;
          state     <= S_FETCH;
`ifndef CB_NODE_STACK_EN
          root      <= root_index;
`endif
        end
        S_FETCH: begin
          rd_req <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: if (rd_valid) begin
          left_c  <= rd_left;
          right_c <= rd_right;
          state   <= ret_st;
        end
        S_LEFT, S_RIGHT: begin
          if (c_null) begin
            // NULL on the left is only legal at the root (empty tree).
            if (is_right) state <= S_BACK;
            else if (len == '0) begin
              state <= S_DONE; busy <= 1'b0; done <= 1'b1;
            end else begin
              state <= S_ERROR; busy <= 1'b0; error <= 1'b1;
            end
          end else if (at_max) begin
            state <= S_ERROR; busy <= 1'b0; error <= 1'b1;
          end else if (c_leaf) begin
            // Leaf: record uses path+edge but the walk stays on this node.
            code_valid <= 1'b1;
            code_sym   <= cur[SYM_W-1:0];
            code_bits  <= path_push;
            code_len   <= len_inc;
            emit_ret   <= is_right ? S_BACK : S_RIGHT;
            state      <= S_EMIT;
          end else begin
            path    <= path_push;
            len     <= len_inc;
            rd_req  <= 1'b1;
            rd_addr <= cur[IDX_W-1:0];
            ret_st  <= S_LEFT;
            state   <= S_FETCH;
          end
        end
        S_EMIT: if (code_ready) begin
          code_valid <= 1'b0;
          sym_count  <= sym_count + CNT_ONE;
          state      <= emit_ret;
        end
        S_BACK: begin
          if (len == '0) begin
            state <= S_DONE; busy <= 1'b0; done <= 1'b1;
          end else begin
            path <= path >> 1;
            len  <= len_dec;
            // Came up a left edge: parent's right side is still pending.
            if (!path[0]) begin
              rd_req  <= 1'b1;
              state   <= S_FETCH;
`ifdef CB_NODE_STACK_EN
              rd_addr <= parent;
              ret_st  <= S_RIGHT;
`else
              rd_addr <= root;
              k       <= '0;
              ret_st  <= S_REWALK;
`endif
            end
          end
        end
`ifndef CB_NODE_STACK_EN
        S_REWALK: begin
          if (k == len) state <= S_RIGHT;
          else begin
            rd_req  <= 1'b1;
            rd_addr <= rw_child;
            k       <= k + LEN_ONE;
            ret_st  <= S_REWALK;
            state   <= S_FETCH;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_cb_walker.sv
// Bench for t05_cb_walker: d0 uses default depth, d1 uses MAX_DEPTH=2 for the
// depth-overflow case. Node memory model responds after `lat` enabled cycles.
`define CHK(nm, a, e) chk(nm, 160'(a), 160'(e))

module tb_t05_cb_walker;

  localparam logic [8:0] NUL = 9'h180;
`ifdef CB_NODE_STACK_EN
  localparam int T3_READS = 5;
`else
  localparam int T3_READS = 6;
`endif

  typedef struct packed {
    logic [7:0]   sym;
    logic [127:0] bits;
    logic [7:0]   len;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst, en, code_ready;
  logic [1:0] start;
  logic [6:0] root_index;

  logic       rd_req [2], rd_valid [2], code_valid [2], busy [2], done [2], error [2];
  logic [6:0] rd_addr [2];
  logic [8:0] rd_left [2], rd_right [2], sym_count [2];
  logic [7:0] code_sym [2];
  logic [127:0] bits0;
  logic [7:0]   len0;
  logic [1:0]   bits1, len1;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  t05_cb_walker #(.IDX_W(7), .SYM_W(8), .MAX_DEPTH(128)) d0 (
    .clk(clk), .rst(rst), .en(en), .start(start[0]), .root_index(root_index),
    .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_valid(rd_valid[0]),
    .rd_left(rd_left[0]), .rd_right(rd_right[0]),
    .code_valid(code_valid[0]), .code_ready(code_ready), .code_sym(code_sym[0]),
    .code_bits(bits0), .code_len(len0), .sym_count(sym_count[0]),
    .busy(busy[0]), .done(done[0]), .error(error[0]));

  t05_cb_walker #(.IDX_W(7), .SYM_W(8), .MAX_DEPTH(2)) d1 (
    .clk(clk), .rst(rst), .en(en), .start(start[1]), .root_index(root_index),
    .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_valid(rd_valid[1]),
    .rd_left(rd_left[1]), .rd_right(rd_right[1]),
    .code_valid(code_valid[1]), .code_ready(code_ready), .code_sym(code_sym[1]),
    .code_bits(bits1), .code_len(len1), .sym_count(sym_count[1]),
    .busy(busy[1]), .done(done[1]), .error(error[1]));

  // ---------------- node memory model ----------------
  logic [8:0] mem_l [128], mem_r [128];
  int         lat;
  int         pend_cnt [2];
  logic [6:0] pend_addr [2];
  int         rd_cnt [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rd_valid[i] <= 1'b0; pend_cnt[i] <= 0; pend_addr[i] <= '0;
        rd_left[i] <= '0; rd_right[i] <= '0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        rd_valid[i] <= 1'b0;
        if (rd_req[i]) begin
          pend_cnt[i] <= lat; pend_addr[i] <= rd_addr[i]; rd_cnt[i] <= rd_cnt[i] + 1;
        end else if (pend_cnt[i] == 1) begin
          rd_valid[i] <= 1'b1;
          rd_left[i]  <= mem_l[pend_addr[i]];
          rd_right[i] <= mem_r[pend_addr[i]];
          pend_cnt[i] <= 0;
        end else if (pend_cnt[i] > 1) pend_cnt[i] <= pend_cnt[i] - 1;
      end
    end
  end

  // ---------------- behavioural model ----------------
  rec_t exp_q [$];

  function automatic void build_model(input logic [6:0] r);
    logic [8:0]   sc [$];
    logic [127:0] sb [$];
    int           sl [$];
    logic [8:0]   c;
    logic [127:0] b;
    int           l;
    rec_t         e;
    exp_q.delete();
    if (mem_l[r] == NUL) return;
    sc.push_back(mem_r[r]); sb.push_back(128'd1); sl.push_back(1);
    sc.push_back(mem_l[r]); sb.push_back(128'd0); sl.push_back(1);
    while (sc.size() > 0) begin
      c = sc.pop_back(); b = sb.pop_back(); l = sl.pop_back();
      if (c == NUL) continue;
      if (!c[8]) begin
        e.sym = c[7:0]; e.bits = b; e.len = 8'(l);
        exp_q.push_back(e);
      end else begin
        sc.push_back(mem_r[c[6:0]]); sb.push_back((b << 1) | 128'd1); sl.push_back(l + 1);
        sc.push_back(mem_l[c[6:0]]); sb.push_back(b << 1);           sl.push_back(l + 1);
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  rec_t m_cur, m_exp, m_prev;
  logic m_hold = 1'b0;
  int   d1_cv = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (code_valid[0]) begin
        m_cur.sym = code_sym[0]; m_cur.bits = bits0; m_cur.len = len0;
        checks++;
        if (rd_req[0] !== 1'b0) begin
          errors++; $display("FAIL rdreq_in_emit: rd_req=%b", rd_req[0]);
        end
        if (m_hold) begin
          checks++;
          if (m_cur !== m_prev) begin
            errors++; $display("FAIL stall_stable: got 0x%0h expected 0x%0h", m_cur, m_prev);
          end
        end
        if (en && code_ready) begin
          if (exp_q.size() == 0) `CHK("unexpected_record", m_cur, 0);
          else begin
            m_exp = exp_q.pop_front();
            checks++;
            if (m_cur !== m_exp) begin
              errors++; $display("FAIL record: got 0x%0h expected 0x%0h", m_cur, m_exp);
            end
          end
          m_hold = 1'b0;
        end else begin
          m_hold = 1'b1; m_prev = m_cur;
        end
      end else m_hold = 1'b0;
      if (code_valid[1]) d1_cv++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_walk(input int i, input logic [6:0] r);
    root_index = r; start[i] = 1'b1; cyc(1); start[i] = 1'b0;
  endtask

  task automatic wait_end(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (done[i] || error[i]) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic wait_cv(input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (code_valid[0]) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  initial begin
    bit ok;
    int base;
    logic [36:0] snap;
    rst = 1'b1; en = 1'b1; start = '0; code_ready = 1'b1; root_index = '0; lat = 1;
    for (int i = 0; i < 128; i++) begin mem_l[i] = NUL; mem_r[i] = NUL; end
    mem_l[0] = 9'h041; mem_r[0] = 9'h042;
    mem_l[5] = NUL;    mem_r[5] = NUL;
    mem_l[3] = 9'h102; mem_r[3] = 9'h044;
    mem_l[2] = 9'h101; mem_r[2] = 9'h043;
    mem_l[1] = 9'h041; mem_r[1] = 9'h042;
    cyc(3);
    `CHK("reset_d0", ({busy[0],done[0],error[0],code_valid[0],rd_req[0],sym_count[0],code_sym[0],rd_addr[0],len0}), 0);
    `CHK("reset_d0_bits", bits0, 0);
    `CHK("reset_d1", ({busy[1],done[1],error[1],code_valid[1],rd_req[1],sym_count[1],bits1,len1}), 0);
    rst = 1'b0; cyc(2);
    `CHK("idle_d0", ({busy[0],done[0],error[0],code_valid[0],rd_req[0]}), 0);

    // T1
    build_model(7'd0);
    `CHK("t1_model_n", exp_q.size(), 2);
    `CHK("t1_model_r0", exp_q[0], ({8'h41, 128'd0, 8'd1}));
    `CHK("t1_model_r1", exp_q[1], ({8'h42, 128'd1, 8'd1}));
    base = rd_cnt[0];
    start_walk(0, 7'd0);
    `CHK("t1_busy", busy[0], 1'b1);
    wait_end(0, 200, ok);
    `CHK("t1_finished", ok, 1'b1);
    `CHK("t1_status", ({done[0],error[0],busy[0]}), 3'b100);
    checks++;
    if (sym_count[0] !== 9'd2) begin
      errors++; $display("FAIL t1_sym_count: got %0d expected 2", sym_count[0]);
    end
    `CHK("t1_reads", rd_cnt[0] - base, 1);
    `CHK("t1_all_records", exp_q.size(), 0);

    // T2
    build_model(7'd5);
    `CHK("t2_model_n", exp_q.size(), 0);
    start_walk(0, 7'd5);
    wait_end(0, 200, ok);
    `CHK("t2_finished", ok, 1'b1);
    `CHK("t2_status", ({done[0],error[0]}), 2'b10);
    `CHK("t2_sym_count", sym_count[0], 0);

    // T3
    build_model(7'd3);
    `CHK("t3_model_n", exp_q.size(), 4);
    `CHK("t3_model_a", exp_q[0], ({8'h41, 128'd0, 8'd3}));
    `CHK("t3_model_b", exp_q[1], ({8'h42, 128'd1, 8'd3}));
    `CHK("t3_model_c", exp_q[2], ({8'h43, 128'd1, 8'd2}));
    `CHK("t3_model_d", exp_q[3], ({8'h44, 128'd1, 8'd1}));
    base = rd_cnt[0];
    start_walk(0, 7'd3);
    wait_end(0, 400, ok);
    `CHK("t3_finished", ok, 1'b1);
    `CHK("t3_status", ({done[0],error[0]}), 2'b10);
    checks++;
    if (sym_count[0] !== 9'd4) begin
      errors++; $display("FAIL t3_sym_count: got %0d expected 4", sym_count[0]);
    end
    checks++;
    if ((rd_cnt[0] - base) != T3_READS) begin
      errors++; $display("FAIL t3_reads: got %0d expected %0d", rd_cnt[0] - base, T3_READS);
    end
    `CHK("t3_all_records", exp_q.size(), 0);

    // T4
    build_model(7'd3);
    code_ready = 1'b0;
    start_walk(0, 7'd3);
    wait_cv(200, ok);
    `CHK("t4_rec_a_seen", ok, 1'b1);
    code_ready = 1'b1; cyc(1); code_ready = 1'b0;
    wait_cv(200, ok);
    `CHK("t4_rec_b_seen", ok, 1'b1);
    `CHK("t4_rec_b_sym", code_sym[0], 8'h42);
    base = rd_cnt[0];
    cyc(10);
    `CHK("t4_still_valid", code_valid[0], 1'b1);
    `CHK("t4_no_reads", rd_cnt[0] - base, 0);
    code_ready = 1'b1;
    wait_end(0, 400, ok);
    `CHK("t4_finished", ok, 1'b1);
    `CHK("t4_sym_count", sym_count[0], 4);
    `CHK("t4_all_records", exp_q.size(), 0);

    // T5
    start_walk(1, 7'd3);
    wait_end(1, 400, ok);
    `CHK("t5_finished", ok, 1'b1);
    checks++;
    if ({error[1],busy[1],done[1]} !== 3'b100) begin
      errors++; $display("FAIL t5_status: got %b expected 100", {error[1],busy[1],done[1]});
    end
    `CHK("t5_sym_count", sym_count[1], 0);
    checks++;
    if (d1_cv != 0) begin
      errors++; $display("FAIL t5_no_record: %0d records seen", d1_cv);
    end
    start_walk(1, 7'd3);
    `CHK("t5_restart", ({error[1],busy[1]}), 2'b01);
    wait_end(1, 400, ok);
    `CHK("t5_refinished", ok, 1'b1);

    // T6
    lat = 3;
    build_model(7'd3);
    base = rd_cnt[0];
    start_walk(0, 7'd3);
    cyc(2);
    en = 1'b0;
    snap = {busy[0],done[0],error[0],code_valid[0],rd_req[0],sym_count[0],code_sym[0],rd_addr[0],len0};
    for (int t = 0; t < 5; t++) begin
      cyc(1);
      `CHK("t6_frozen", ({busy[0],done[0],error[0],code_valid[0],rd_req[0],sym_count[0],code_sym[0],rd_addr[0],len0}), snap);
    end
    en = 1'b1;
    wait_end(0, 600, ok);
    `CHK("t6_finished", ok, 1'b1);
    `CHK("t6_sym_count", sym_count[0], 4);
    `CHK("t6_reads", rd_cnt[0] - base, T3_READS);
    `CHK("t6_all_records", exp_q.size(), 0);

    build_model(7'd3);
    start_walk(0, 7'd3);
    cyc(12);
    `CHK("t6_midwalk_busy", busy[0], 1'b1);
    rst = 1'b1; #1;
    `CHK("t6_rst_d0", ({busy[0],done[0],error[0],code_valid[0],rd_req[0],sym_count[0],code_sym[0],rd_addr[0],len0}), 0);
    `CHK("t6_rst_d0_bits", bits0, 0);
    `CHK("t6_rst_d1", ({busy[1],done[1],error[1],code_valid[1],rd_req[1],sym_count[1],bits1,len1}), 0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(20);
    `CHK("t6_post_rst_idle", ({busy[0],done[0],code_valid[0],sym_count[0]}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
